// File: rtl/dmem_responder_pkg.sv
// rtl/dmem_responder_pkg.sv - shared types, sizes and lane helpers for the DMEM responder
package dmem_responder_pkg;

    localparam int MEM_ADDR_WIDTH  = 32;
    localparam int MEM_WORD_WIDTH  = 32;
    localparam int IMEM_BYTES      = 32'h0000_4000;
    localparam int DMEM_BYTES      = 49152;
    localparam int ERR_ENUMS_WIDTH = 2;

    typedef enum logic [1:0] {
        NB_WORD    = 2'b00,
        NB_SINGLE  = 2'b01,
        NB_HALF    = 2'b10,
        NB_ILLEGAL = 2'b11
    } e_num_bytes;

    typedef enum logic [ERR_ENUMS_WIDTH-1:0] {
        ERR_NONE     = 2'b00,
        ERR_MISALIGN = 2'b01,
        ERR_RANGE    = 2'b10,
        ERR_SIZE     = 2'b11
    } e_dmem_err;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_SPLIT,
        ST_RESP
    } e_dmem_state;

    // Byte enables for an access that fits inside one naturally aligned word.
    function automatic logic [3:0] lane_mask(input e_num_bytes n_bytes, input logic [1:0] offset);
        case (n_bytes)
            NB_SINGLE: lane_mask = 4'b0001 << offset;
            NB_HALF:   lane_mask = 4'b0011 << {offset[1], 1'b0};
            NB_WORD:   lane_mask = 4'b1111;
            default:   lane_mask = 4'b0000;
        endcase
    endfunction

    // Byte enables over a two-word window; bits [7:4] address the following word.
    function automatic logic [7:0] span_mask(input e_num_bytes n_bytes, input logic [1:0] offset);
        case (n_bytes)
            NB_SINGLE: span_mask = 8'h01 << offset;
            NB_HALF:   span_mask = 8'h03 << offset;
            NB_WORD:   span_mask = 8'h0F << offset;
            default:   span_mask = 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// rtl/dmem_responder_if.sv - LSU request/response channel between core and DMEM responder
interface dmem_responder_if
    import dmem_responder_pkg::*;
#(
    parameter int ADDR_W = MEM_ADDR_WIDTH,
    parameter int DATA_W = MEM_WORD_WIDTH
) ();
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    e_num_bytes        req_n_bytes;
    logic              req_unsigned;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    e_dmem_err         rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_n_bytes, req_unsigned, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_n_bytes, req_unsigned, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dmem_word_ram.sv
// rtl/dmem_word_ram.sv - single-port word RAM, byte write enables, sync write, comb read
module dmem_word_ram #(
    parameter int WORDS  = 12288,
    parameter int DATA_W = 32,
    parameter int IDX_W  = $clog2(WORDS)
) (
    input  logic                clk,
    input  logic [DATA_W/8-1:0] we,
    input  logic [IDX_W-1:0]    idx,
    input  logic [DATA_W-1:0]   wdata,
    output logic [DATA_W-1:0]   rdata
);
    logic [DATA_W-1:0] mem [WORDS];

    always_ff @(posedge clk) begin
        for (int b = 0; b < DATA_W/8; b++) begin
            if (we[b]) begin
                mem[idx][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    assign rdata = mem[idx];
endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - DMEM load/store responder; DMEM_MISALIGN_SPLIT_EN enables split misaligned access
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int                ADDR_W      = MEM_ADDR_WIDTH,
    parameter int                DATA_W      = MEM_WORD_WIDTH,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = ADDR_W'(IMEM_BYTES),
    parameter int                DEPTH_BYTES = DMEM_BYTES,
    parameter int                LATENCY     = 1
) (
    input logic             clk,
    input logic             rst_n,
    dmem_responder_if.slave bus
);
    localparam int              WORDS     = DEPTH_BYTES / 4;
    localparam int              IDX_W     = $clog2(WORDS);
    localparam logic [ADDR_W:0] RANGE_END = {1'b0, BASE_ADDR} + (ADDR_W+1)'(DEPTH_BYTES);

    e_dmem_state       state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    e_num_bytes        nb_q, nb_d;
    logic              uns_q, uns_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    e_dmem_err         err_q, err_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    e_dmem_err         rerr_q, rerr_d;

    e_dmem_err         dec_err;
    logic [2:0]        size;
    logic [ADDR_W:0]   last_byte;
    logic [1:0]        off;
    logic [IDX_W-1:0]  idx_base, ram_idx;
    logic [3:0]        ram_we;
    logic [DATA_W-1:0] ram_wdata, ram_rdata;
    logic              last_beat;
`ifdef DMEM_MISALIGN_SPLIT_EN
    logic [DATA_W-1:0] lo_q, lo_d;
    logic [7:0]        span;
    logic [63:0]       wdata64;
    logic              crossing;
`endif

    function automatic logic [31:0] extend(input logic [63:0] win, input logic [1:0] offset,
                                           input e_num_bytes nb, input logic uns);
        logic [31:0] sh;
        sh = 32'(win >> {offset, 3'b000});
        case (nb)
            NB_SINGLE: extend = {{24{sh[7] & ~uns}}, sh[7:0]};
            NB_HALF:   extend = {{16{sh[15] & ~uns}}, sh[15:0]};
            default:   extend = sh;
        endcase
    endfunction

    // Decode on the live request; the extra address bit keeps the top-of-map check from wrapping.
    always_comb begin
        case (bus.req_n_bytes)
            NB_SINGLE: size = 3'd1;
            NB_HALF:   size = 3'd2;
            NB_WORD:   size = 3'd4;
            default:   size = 3'd0;
        endcase
        last_byte = {1'b0, bus.req_addr} + (ADDR_W+1)'(size) - (ADDR_W+1)'(1);
        if (bus.req_n_bytes == NB_ILLEGAL) begin
            dec_err = ERR_SIZE;
        end else if (bus.req_addr < BASE_ADDR || last_byte >= RANGE_END) begin
            dec_err = ERR_RANGE;
`ifndef DMEM_MISALIGN_SPLIT_EN
        end else if ((bus.req_n_bytes == NB_HALF && bus.req_addr[0]) ||
                     (bus.req_n_bytes == NB_WORD && bus.req_addr[1:0] != 2'b00)) begin
            dec_err = ERR_MISALIGN;
`endif
        end else begin
            dec_err = ERR_NONE;
        end
    end

    always_comb begin
        off       = addr_q[1:0];
        idx_base  = IDX_W'((addr_q - BASE_ADDR) >> 2);
        last_beat = (state_q == ST_ACCESS) && (cnt_q == 4'd0);
        ram_idx   = idx_base;
        ram_we    = 4'b0000;
`ifdef DMEM_MISALIGN_SPLIT_EN
        span      = span_mask(nb_q, off);
        crossing  = |span[7:4];
        wdata64   = {32'b0, wdata_q} << {off, 3'b000};
        ram_wdata = wdata64[31:0];
        if (rst_n && we_q && err_q == ERR_NONE) begin
            if (last_beat) begin
                ram_we = span[3:0];
            end else if (state_q == ST_SPLIT) begin
                ram_we = span[7:4];
            end
        end
        if (state_q == ST_SPLIT) begin
            ram_idx   = idx_base + IDX_W'(1);
            ram_wdata = wdata64[63:32];
        end
`else
        ram_wdata = wdata_q << {off, 3'b000};
        if (rst_n && we_q && err_q == ERR_NONE && last_beat) begin
            ram_we = lane_mask(nb_q, off);
        end
`endif
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        nb_d    = nb_q;
        uns_d   = uns_q;
        wdata_d = wdata_q;
        err_d   = err_q;
        rdata_d = rdata_q;
        rerr_d  = rerr_q;
`ifdef DMEM_MISALIGN_SPLIT_EN
        lo_d    = lo_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    we_d    = bus.req_we;
                    addr_d  = bus.req_addr;
                    nb_d    = bus.req_n_bytes;
                    uns_d   = bus.req_unsigned;
                    wdata_d = bus.req_wdata;
                    err_d   = dec_err;
                    cnt_d   = 4'(LATENCY - 1);
                    state_d = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    rerr_d  = err_q;
                    rdata_d = '0;
                    state_d = ST_RESP;
`ifdef DMEM_MISALIGN_SPLIT_EN
                    if (err_q == ERR_NONE && crossing) begin
                        lo_d    = ram_rdata;
                        state_d = ST_SPLIT;
                    end else
`endif
                    if (err_q == ERR_NONE && !we_q) begin
                        rdata_d = extend({32'b0, ram_rdata}, off, nb_q, uns_q);
                    end
                end
            end
`ifdef DMEM_MISALIGN_SPLIT_EN
            ST_SPLIT: begin
                if (!we_q) begin
                    rdata_d = extend({ram_rdata, lo_q}, off, nb_q, uns_q);
                end
                state_d = ST_RESP;
            end
`endif
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            rdata_q <= '0;
            rerr_q  <= ERR_NONE;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            rerr_q  <= rerr_d;
        end
    end

    // Captured request fields are only meaningful after an accept, so they carry no reset.
    always_ff @(posedge clk) begin
        we_q    <= we_d;
        addr_q  <= addr_d;
        nb_q    <= nb_d;
        uns_q   <= uns_d;
        wdata_q <= wdata_d;
        err_q   <= err_d;
`ifdef DMEM_MISALIGN_SPLIT_EN
        lo_q    <= lo_d;
`endif
    end

    dmem_word_ram #(
        .WORDS  (WORDS),
        .DATA_W (DATA_W),
        .IDX_W  (IDX_W)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .idx   (ram_idx),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    assign bus.req_ready = rst_n && (state_q == ST_IDLE);
    assign bus.rsp_valid = (state_q == ST_RESP);
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = rerr_q;
endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - scoreboard bench for dmem_responder against a byte-array reference model
module tb_dmem_responder;
    import dmem_responder_pkg::*;

    localparam int     LAT   = 3;
    localparam longint BASE  = 64'h4000;
    localparam longint DEPTH = 49152;

    typedef struct {
        logic [31:0] rdata;
        e_dmem_err   err;
        int          lat;
        int          acc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dmem_responder_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    dmem_responder #(.LATENCY(LAT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    exp_t      exp_q[$];
    bit [7:0]  mdl [int unsigned];
    int        checks = 0;
    int        errors = 0;
    int        cyc = 0;
    int        force_stall = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%08h, required 0x%08h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference model: byte-addressed memory and the access rules, evaluated at issue time.
    task automatic issue(input bit we, input int unsigned addr, input int nb, input bit uns,
                         input logic [31:0] wd);
        exp_t        e;
        int          n;
        int          waited;
        longint      last;
        logic [31:0] v;
        n    = (nb == 0) ? 4 : (nb == 1) ? 1 : (nb == 2) ? 2 : 0;
        last = longint'(addr) + n - 1;
        if (nb == 3)                                   e.err = ERR_SIZE;
        else if (addr < BASE || last >= BASE + DEPTH)  e.err = ERR_RANGE;
`ifndef DMEM_MISALIGN_SPLIT_EN
        else if (addr % n != 0)                        e.err = ERR_MISALIGN;
`endif
        else                                           e.err = ERR_NONE;
        e.lat = LAT;
`ifdef DMEM_MISALIGN_SPLIT_EN
        if (e.err == ERR_NONE && (addr % 4) + n > 4) e.lat = LAT + 1;
`endif
        e.rdata = 32'h0;
        if (e.err == ERR_NONE) begin
            if (we) begin
                for (int i = 0; i < n; i++) mdl[addr + i] = wd[8*i +: 8];
            end else begin
                v = 32'h0;
                for (int i = 0; i < n; i++) v[8*i +: 8] = mdl.exists(addr + i) ? mdl[addr + i] : 8'h00;
                if (n < 4 && !uns && v[8*n-1]) begin
                    for (int i = 8*n; i < 32; i++) v[i] = 1'b1;
                end
                e.rdata = v;
            end
        end

        @(negedge clk);
        bus.req_valid    = 1'b1;
        bus.req_we       = we;
        bus.req_addr     = addr;
        bus.req_n_bytes  = e_num_bytes'(nb[1:0]);
        bus.req_unsigned = uns;
        bus.req_wdata    = wd;
        waited = 0;
        while (!bus.req_ready && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (!bus.req_ready) begin
            checks++;
            errors++;
            $display("FAIL req_timeout: req_ready stayed 0, required 1");
            bus.req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        e.acc = cyc;
        exp_q.push_back(e);
        bus.req_valid    = 1'b0;
        bus.req_we       = 1'($urandom);
        bus.req_addr     = $urandom;
        bus.req_n_bytes  = e_num_bytes'($urandom_range(0, 3));
        bus.req_unsigned = 1'($urandom);
        bus.req_wdata    = $urandom;
    endtask

    initial begin : monitor
        int   stall_cnt;
        bit   seen;
        exp_t e;
        stall_cnt     = 0;
        seen          = 1'b0;
        bus.rsp_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                seen          = 1'b0;
                bus.rsp_ready = 1'b0;
            end else if (bus.rsp_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_rsp: got rsp_valid=1 with no request outstanding, required 0");
                    bus.rsp_ready = 1'b1;
                end else begin
                    if (!seen) begin
                        seen = 1'b1;
                        check("latency", 32'(cyc - exp_q[0].acc), 32'(exp_q[0].lat));
                        stall_cnt   = (force_stall > 0) ? force_stall : $urandom_range(0, 2);
                        force_stall = 0;
                    end else begin
                        check("hold_rdata", bus.rsp_rdata, exp_q[0].rdata);
                        check("hold_err", 32'(bus.rsp_err), 32'(exp_q[0].err));
                        check("hold_req_ready", 32'(bus.req_ready), 32'h0);
                    end
                    if (stall_cnt > 0) begin
                        stall_cnt--;
                        bus.rsp_ready = 1'b0;
                    end else begin
                        e = exp_q.pop_front();
                        check("rsp_rdata", bus.rsp_rdata, e.rdata);
                        check("rsp_err", 32'(bus.rsp_err), 32'(e.err));
                        bus.rsp_ready = 1'b1;
                        seen          = 1'b0;
                    end
                end
            end else begin
                bus.rsp_ready = 1'($urandom_range(0, 1));
            end
        end
    end

    initial begin : stim
        int unsigned edge_addr [6];
        int unsigned a;
        int          nb;
        int          drain;
        edge_addr = '{32'h3FFC, 32'h3FFF, 32'hFFFC, 32'hFFFE, 32'h10000, 32'h0};

        bus.req_valid    = 1'b0;
        bus.req_we       = 1'b0;
        bus.req_addr     = 32'h0;
        bus.req_n_bytes  = NB_WORD;
        bus.req_unsigned = 1'b0;
        bus.req_wdata    = 32'h0;
        rst_n            = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_req_ready", 32'(bus.req_ready), 32'h0);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
        check("rst_rsp_rdata", bus.rsp_rdata, 32'h0);
        check("rst_rsp_err", 32'(bus.rsp_err), 32'(ERR_NONE));
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_rst", 32'(bus.req_ready), 32'h1);

        for (int i = 0; i <= 16; i++) issue(1'b1, 32'h4000 + 4*i, 0, 1'b0, $urandom);
        issue(1'b1, 32'hFFFC, 0, 1'b0, $urandom);

        issue(1'b1, 32'h4000, 0, 1'b0, 32'hDEADBEEF);
        issue(1'b0, 32'h4000, 0, 1'b0, 32'h0);
        issue(1'b1, 32'h4000, 0, 1'b0, 32'h80FF1234);
        issue(1'b0, 32'h4003, 1, 1'b0, 32'h0);
        issue(1'b0, 32'h4003, 1, 1'b1, 32'h0);
        issue(1'b0, 32'h4002, 2, 1'b0, 32'h0);
        issue(1'b1, 32'h4004, 0, 1'b0, 32'h11223344);
        issue(1'b1, 32'h4005, 1, 1'b0, 32'h000000AB);
        issue(1'b0, 32'h4004, 0, 1'b0, 32'h0);
        issue(1'b0, 32'h3FFC, 0, 1'b0, 32'h0);
        issue(1'b0, 32'hFFFE, 0, 1'b0, 32'h0);
        issue(1'b0, 32'h4000, 3, 1'b0, 32'h0);
        issue(1'b1, 32'h4001, 2, 1'b0, 32'h0000BEEF);
        force_stall = 5;
        issue(1'b0, 32'h4000, 0, 1'b0, 32'h0);

        // Reset lands on the edge that would commit this store.
        @(negedge clk);
        bus.req_valid   = 1'b1;
        bus.req_we      = 1'b1;
        bus.req_addr    = 32'h4010;
        bus.req_n_bytes = NB_WORD;
        bus.req_wdata   = 32'hCAFEF00D;
        for (int i = 0; i < 100 && !bus.req_ready; i++) @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        repeat (LAT - 1) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_req_ready", 32'(bus.req_ready), 32'h0);
        check("midrst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
        check("midrst_rsp_rdata", bus.rsp_rdata, 32'h0);
        check("midrst_rsp_err", 32'(bus.rsp_err), 32'(ERR_NONE));
        rst_n = 1'b1;
        @(negedge clk);
        check("midrst_ready_after", 32'(bus.req_ready), 32'h1);
        issue(1'b0, 32'h4010, 0, 1'b0, 32'h0);

        for (int k = 0; k < 200; k++) begin
            nb = ($urandom_range(0, 15) == 0) ? 3 : $urandom_range(0, 2);
            if ($urandom_range(0, 9) == 0) begin
                a = edge_addr[$urandom_range(0, 5)];
            end else begin
                a = 32'h4000 + $urandom_range(0, 63);
                if ($urandom_range(0, 1) == 1) a = a & ~((nb == 0) ? 32'h3 : (nb == 2) ? 32'h1 : 32'h0);
            end
            issue(1'($urandom), a, nb, 1'($urandom), $urandom);
        end

        issue(1'b1, 32'h4000, 0, 1'b0, 32'h44332211);
        issue(1'b1, 32'h4004, 0, 1'b0, 32'h88776655);
        issue(1'b0, 32'h4002, 0, 1'b0, 32'h0);
        issue(1'b0, 32'h4003, 2, 1'b0, 32'h0);

        drain = 0;
        while (exp_q.size() != 0 && drain < 200) begin
            @(negedge clk);
            drain++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d responses outstanding, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
